i2c_txn_sched: RTL and testbench
================================

// Module: i2c_txn_sched
// PURPOSE
//  Upstream command scheduler for the free-running i2c_mem master/memory pair. Queues host
//  read/write commands, drives i2c_mem's wr/addr/din for exactly one transaction at a time,
//  and retires each transaction on done, returning read data and status through a response FIFO.
//  i2c_mem has no start input, so an empty queue is covered by "filler" reads whose results are discarded.
// PARAMETERS
//  CMD_DEPTH    4      command FIFO entries (power of 2, >=2)
//  RSP_DEPTH    4      response FIFO entries (power of 2, >=2)
//  TIMEOUT      1024   cycles without done before the in-flight transaction is declared failed
//  FILLER_ADDR  7'h7F  address used for filler reads
// PORTS
//  clk        in   1  single clock, all logic on posedge
//  rst        in   1  asynchronous, active-low reset (asserted when 0)
//  cmd_valid  in   1  host command valid
//  cmd_ready  out  1  command FIFO not full
//  cmd_wr     in   1  1 = write, 0 = read
//  cmd_addr   in   7  target memory address
//  cmd_data   in   8  write data (ignored for reads)
//  rsp_valid  out  1  response FIFO not empty
//  rsp_ready  in   1  host accepts response
//  rsp_wr     out  1  echo of command type
//  rsp_addr   out  7  echo of command address
//  rsp_data   out  8  read data (0 for writes and errors)
//  rsp_err    out  1  1 = transaction timed out
//  i2c_wr     out  1  to i2c_mem.wr
//  i2c_addr   out  7  to i2c_mem.addr
//  i2c_din    out  8  to i2c_mem.din
//  i2c_datard in   8  from i2c_mem.datard
//  i2c_done   in   1  from i2c_mem.done (1-cycle pulse, asserted during i2c_mem idle)
//  busy       out  1  in-flight slot holds a real (non-filler) command
//  err_sticky out  1  set on any timeout; cleared only by reset
// BEHAVIOUR
//  Reset values: cmd_ready=1, rsp_valid=0, rsp_*=0, i2c_wr=0, i2c_addr=FILLER_ADDR, i2c_din=0,
//   busy=0, err_sticky=0; both FIFOs empty; timeout counter=0; in-flight slot = filler.
//  Command FIFO: push when cmd_valid && cmd_ready. Full => cmd_ready=0, no push.
//  In-flight slot {real, wr, addr, data}; i2c_* outputs are registered copies, constant between dones.
//  On i2c_done=1 (same posedge, i.e. before i2c_mem's start state samples addr):
//   1. retire: if real, push {wr, addr, wr ? 0 : i2c_datard, err=0} into response FIFO;
//      filler results are discarded.
//   2. load: if cmd FIFO non-empty AND credits available, pop head into the slot (real=1);
//      otherwise load filler {real=0, wr=0, addr=FILLER_ADDR, din=0}.
//   3. timeout counter <= 0.
//  Credits: load only if (rsp FIFO count + retiring push) < RSP_DEPTH, so a response
//   push never finds the response FIFO full; responses are never dropped.
//  Timeout: counter increments every cycle without done, saturating at TIMEOUT. On reaching TIMEOUT:
//   err_sticky<=1; if real, push {wr, addr, 0, err=1} and mark slot real=0. i2c_* outputs stay unchanged
//   (no mid-transaction change). A later done retires nothing and reloads normally.
//  Simultaneous cmd push and pop: both occur; count unchanged. A pop on a full FIFO frees a slot next cycle.
//  Simultaneous rsp push and pop: both occur; rsp_* shows the head entry (first-word-fall-through).
//  Ordering: responses return in command order; wrap-around uses log2(DEPTH)+1-bit pointers.
//  Reset mid-transaction: all queues flushed, slot -> filler. No response is issued for lost commands.
// TESTING
//  1. Reset, no cmds: filler reads run continuously; i2c_addr=7'h7F, i2c_wr=0; rsp_valid stays 0.
//  2. Write 0x5A to 0x12, then read 0x12 -> rsp1 {wr=1, addr=12, data=00, err=0},
//     rsp2 {wr=0, addr=12, data=5A, err=0}, in order.
//  3. Push 5 cmds with CMD_DEPTH=4 while blocked -> cmd_ready=0 after 4; 5th accepted once the first pops.
//  4. Hold rsp_ready=0, issue 6 reads -> only 4 reach the slot; no response lost; drain yields 6 in order.
//  5. Tie i2c_done=0 for 1024 cycles with a real read in flight -> rsp {err=1, data=00}; err_sticky=1;
//     i2c_* outputs unchanged.
//  6. Assert rst low mid-write -> all outputs at reset values immediately (async); FIFOs empty after release.

Source files
------------

// File: rtl/i2c_txn_sched.sv
// Command scheduler for the free-running i2c_mem master/memory pair: queues host commands,
// presents exactly one transaction at a time to i2c_mem and returns results in command order.
module i2c_txn_sched #(
  parameter int         CMD_DEPTH   = 4,
  parameter int         RSP_DEPTH   = 4,
  parameter int         TIMEOUT     = 1024,
  parameter logic [6:0] FILLER_ADDR = 7'h7F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_wr,
  output logic [6:0] rsp_addr,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       i2c_wr,
  output logic [6:0] i2c_addr,
  output logic [7:0] i2c_din,
  input  logic [7:0] i2c_datard,
  input  logic       i2c_done,
  output logic       busy,
  output logic       err_sticky
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef struct packed { logic wr; logic [6:0] addr; logic [7:0] data; } cmd_t;
  typedef struct packed { logic wr; logic [6:0] addr; logic [7:0] data; logic err; } rsp_t;
  typedef struct packed { logic is_real; cmd_t cmd; } slot_t;

  localparam slot_t FILLER = slot_t'({1'b0, 1'b0, FILLER_ADDR, 8'h00});

  cmd_t            cmd_mem [CMD_DEPTH];
  rsp_t            rsp_mem [RSP_DEPTH];
  logic [CAW:0]    cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
  logic [RAW:0]    rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
  slot_t           slot_q, slot_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_q, err_d;

  logic            cmd_empty, cmd_full, cmd_push, cmd_pop;
  logic            rsp_empty, rsp_push, rsp_pop;
  logic            retire_push, credit_ok, tmo_hit;
  logic [RAW:0]    rsp_cnt;
  rsp_t            rsp_wdata, rsp_head;

  assign cmd_empty   = (cmd_wp_q == cmd_rp_q);
  assign cmd_full    = (cmd_wp_q[CAW] != cmd_rp_q[CAW]) &&
                       (cmd_wp_q[CAW-1:0] == cmd_rp_q[CAW-1:0]);
  assign rsp_empty   = (rsp_wp_q == rsp_rp_q);
  assign rsp_cnt     = rsp_wp_q - rsp_rp_q;
  assign cmd_push    = cmd_valid && !cmd_full;
  assign rsp_pop     = !rsp_empty && rsp_ready;
  assign retire_push = i2c_done && slot_q.is_real;
  // A command is only launched if its eventual response is guaranteed a free entry.
  assign credit_ok   = ({1'b0, rsp_cnt} + (RAW+2)'(retire_push)) < (RAW+2)'(RSP_DEPTH);
  assign tmo_hit     = !i2c_done && (tmo_q == TW'(TIMEOUT - 1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    slot_d    = slot_q;
    tmo_d     = tmo_q;
    err_d     = err_q | tmo_hit;
    rsp_push  = 1'b0;
    rsp_wdata = '0;
    cmd_pop   = 1'b0;
    if (i2c_done) begin
      tmo_d     = '0;
      rsp_push  = slot_q.is_real;
      rsp_wdata = {slot_q.cmd.wr, slot_q.cmd.addr,
                   slot_q.cmd.wr ? 8'h00 : i2c_datard, 1'b0};
      if (!cmd_empty && credit_ok) begin
        cmd_pop = 1'b1;
        slot_d  = {1'b1, cmd_mem[cmd_rp_q[CAW-1:0]]};
      end else begin
        slot_d  = FILLER;
      end
    end else begin
      if (tmo_q != TW'(TIMEOUT)) tmo_d = tmo_q + 1'b1;
      if (tmo_hit) begin
        // i2c_* stay frozen; only the bookkeeping drops the command.
        rsp_push       = slot_q.is_real;
        rsp_wdata      = {slot_q.cmd.wr, slot_q.cmd.addr, 8'h00, 1'b1};
        slot_d.is_real = 1'b0;
      end
    end
    cmd_wp_d = cmd_wp_q + (CAW+1)'(cmd_push);
    cmd_rp_d = cmd_rp_q + (CAW+1)'(cmd_pop);
    rsp_wp_d = rsp_wp_q + (RAW+1)'(rsp_push);
    rsp_rp_d = rsp_rp_q + (RAW+1)'(rsp_pop);
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wp_q[CAW-1:0]] <= {cmd_wr, cmd_addr, cmd_data};
    if (rsp_push) rsp_mem[rsp_wp_q[RAW-1:0]] <= rsp_wdata;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_wp_q <= '0;
      cmd_rp_q <= '0;
      rsp_wp_q <= '0;
      rsp_rp_q <= '0;
      slot_q   <= FILLER;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      cmd_wp_q <= cmd_wp_d;
      cmd_rp_q <= cmd_rp_d;
      rsp_wp_q <= rsp_wp_d;
      rsp_rp_q <= rsp_rp_d;
      slot_q   <= slot_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  assign rsp_head   = rsp_mem[rsp_rp_q[RAW-1:0]];
  assign cmd_ready  = !cmd_full;
  assign rsp_valid  = !rsp_empty;
  assign rsp_wr     = rsp_valid & rsp_head.wr;
  assign rsp_addr   = rsp_valid ? rsp_head.addr : 7'h00;
  assign rsp_data   = rsp_valid ? rsp_head.data : 8'h00;
  assign rsp_err    = rsp_valid & rsp_head.err;
  assign i2c_wr     = slot_q.cmd.wr;
  assign i2c_addr   = slot_q.cmd.addr;
  assign i2c_din    = slot_q.cmd.data;
  assign busy       = slot_q.is_real;
  assign err_sticky = err_q;
endmodule

// File: tb/tb_i2c_txn_sched.sv
// Directed bench for i2c_txn_sched: the bench plays i2c_mem by pulsing i2c_done and driving
// i2c_datard, and checks every expected value against hand-computed constants.
module tb_i2c_txn_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_wr, rsp_err;
  logic [6:0] rsp_addr;
  logic [7:0] rsp_data;
  logic       i2c_wr, i2c_done = 1'b0, busy, err_sticky;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_din, i2c_datard = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  i2c_txn_sched dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .i2c_wr(i2c_wr), .i2c_addr(i2c_addr), .i2c_din(i2c_din),
    .i2c_datard(i2c_datard), .i2c_done(i2c_done),
    .busy(busy), .err_sticky(err_sticky)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic wr, input logic [6:0] addr,
                           input logic [7:0] data, input logic err);
    check({tag, ".valid"}, 32'(rsp_valid), 1);
    check({tag, ".wr"},    32'(rsp_wr),    32'(wr));
    check({tag, ".addr"},  32'(rsp_addr),  32'(addr));
    check({tag, ".data"},  32'(rsp_data),  32'(data));
    check({tag, ".err"},   32'(rsp_err),   32'(err));
  endtask

  task automatic push_cmd(input logic wr, input logic [6:0] addr, input logic [7:0] data);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_data = data;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic done_pulse(input logic [7:0] d);
    i2c_done = 1'b1; i2c_datard = d;
    @(negedge clk);
    i2c_done = 1'b0;
  endtask

  task automatic pop_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values while held in reset
    repeat (3) @(negedge clk);
    check("rst.cmd_ready", 32'(cmd_ready), 1);
    check("rst.rsp_valid", 32'(rsp_valid), 0);
    check("rst.rsp_data",  32'(rsp_data),  0);
    check("rst.i2c_addr",  32'(i2c_addr),  32'h7F);
    check("rst.i2c_wr",    32'(i2c_wr),    0);
    check("rst.i2c_din",   32'(i2c_din),   0);
    check("rst.busy",      32'(busy),      0);
    check("rst.err",       32'(err_sticky), 0);
    rst = 1'b1;
    @(negedge clk);

    // 1: filler reads only, results discarded
    repeat (3) done_pulse(8'hAB);
    check("fill.rsp_valid", 32'(rsp_valid), 0);
    check("fill.i2c_addr",  32'(i2c_addr),  32'h7F);
    check("fill.i2c_wr",    32'(i2c_wr),    0);
    check("fill.busy",      32'(busy),      0);

    // 2: write 0x5A to 0x12, then read it back
    push_cmd(1'b1, 7'h12, 8'h5A);
    push_cmd(1'b0, 7'h12, 8'h00);
    check("wr.busy_before", 32'(busy), 0);
    done_pulse(8'hEE);
    check("wr.busy",     32'(busy),     1);
    check("wr.i2c_wr",   32'(i2c_wr),   1);
    check("wr.i2c_addr", 32'(i2c_addr), 32'h12);
    check("wr.i2c_din",  32'(i2c_din),  32'h5A);
    check("wr.no_rsp",   32'(rsp_valid), 0);
    done_pulse(8'h33);
    check_rsp("rsp1", 1'b1, 7'h12, 8'h00, 1'b0);
    check("rd.i2c_wr",   32'(i2c_wr),   0);
    check("rd.i2c_addr", 32'(i2c_addr), 32'h12);
    done_pulse(8'h5A);
    check("rd.busy_after", 32'(busy), 0);
    check("rd.i2c_addr_after", 32'(i2c_addr), 32'h7F);
    pop_rsp();
    check_rsp("rsp2", 1'b0, 7'h12, 8'h5A, 1'b0);
    pop_rsp();
    check("t2.empty", 32'(rsp_valid), 0);

    // 3: command FIFO full back-pressure
    for (int i = 0; i < 4; i++) push_cmd(1'b1, 7'(8'h20 + i), 8'(8'h10 + i));
    check("full.ready", 32'(cmd_ready), 0);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 7'h24; cmd_data = 8'h14;
    @(negedge clk);
    check("full.held_ready", 32'(cmd_ready), 0);
    check("full.held_busy",  32'(busy), 0);
    i2c_done = 1'b1;
    @(negedge clk);
    i2c_done = 1'b0;
    check("full.pop_ready", 32'(cmd_ready), 1);
    check("full.pop_addr",  32'(i2c_addr), 32'h20);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("full.refull", 32'(cmd_ready), 0);
    for (int i = 0; i < 5; i++) begin
      done_pulse(8'hCC);
      check("drain.addr", 32'(rsp_addr), 32'h20 + i);
      check("drain.data", 32'(rsp_data), 0);
      pop_rsp();
    end
    check("drain.empty", 32'(rsp_valid), 0);
    check("drain.busy",  32'(busy), 0);

    // 4: response back-pressure limits launches to RSP_DEPTH
    for (int i = 0; i < 4; i++) push_cmd(1'b0, 7'(8'h30 + i), 8'h00);
    done_pulse(8'h00);
    push_cmd(1'b0, 7'h34, 8'h00);
    done_pulse(8'hA0);
    push_cmd(1'b0, 7'h35, 8'h00);
    done_pulse(8'hA1);
    done_pulse(8'hA2);
    done_pulse(8'hA3);
    check("cred.busy",     32'(busy),     0);
    check("cred.i2c_addr", 32'(i2c_addr), 32'h7F);
    done_pulse(8'hEE);
    check("cred.still_idle", 32'(busy), 0);
    check_rsp("cred.r0", 1'b0, 7'h30, 8'hA0, 1'b0);
    pop_rsp();
    done_pulse(8'h00);
    check("cred.relaunch", 32'(i2c_addr), 32'h34);
    check_rsp("cred.r1", 1'b0, 7'h31, 8'hA1, 1'b0);
    pop_rsp();
    done_pulse(8'hA4);
    check("cred.launch35", 32'(i2c_addr), 32'h35);
    check_rsp("cred.r2", 1'b0, 7'h32, 8'hA2, 1'b0);
    pop_rsp();
    check_rsp("cred.r3", 1'b0, 7'h33, 8'hA3, 1'b0);
    pop_rsp();
    done_pulse(8'hA5);
    check_rsp("cred.r4", 1'b0, 7'h34, 8'hA4, 1'b0);
    pop_rsp();
    check_rsp("cred.r5", 1'b0, 7'h35, 8'hA5, 1'b0);
    pop_rsp();
    check("cred.empty", 32'(rsp_valid), 0);
    check("cred.no_err", 32'(err_sticky), 0);

    // 5: timeout with a real read in flight
    push_cmd(1'b0, 7'h40, 8'h00);
    done_pulse(8'h00);
    check("tmo.busy", 32'(busy), 1);
    repeat (1023) @(negedge clk);
    check("tmo.edge_err",  32'(err_sticky), 0);
    check("tmo.edge_rsp",  32'(rsp_valid),  0);
    @(negedge clk);
    check("tmo.err",      32'(err_sticky), 1);
    check_rsp("tmo.rsp", 1'b0, 7'h40, 8'h00, 1'b1);
    check("tmo.busy_clr", 32'(busy),     0);
    check("tmo.i2c_addr", 32'(i2c_addr), 32'h40);
    check("tmo.i2c_wr",   32'(i2c_wr),   0);
    done_pulse(8'h77);
    check("tmo.late_done", 32'(i2c_addr), 32'h7F);
    pop_rsp();
    check("tmo.one_rsp", 32'(rsp_valid),  0);
    check("tmo.sticky",  32'(err_sticky), 1);

    // 6: asynchronous reset mid-write with queued state
    push_cmd(1'b1, 7'h50, 8'h77);
    push_cmd(1'b1, 7'h52, 8'h66);
    done_pulse(8'h00);
    done_pulse(8'h00);
    push_cmd(1'b0, 7'h53, 8'h00);
    check("ar.pre_busy",  32'(busy),      1);
    check("ar.pre_rsp",   32'(rsp_valid), 1);
    #2 rst = 1'b0;
    #1;
    check("ar.busy",      32'(busy),       0);
    check("ar.i2c_wr",    32'(i2c_wr),     0);
    check("ar.i2c_addr",  32'(i2c_addr),   32'h7F);
    check("ar.i2c_din",   32'(i2c_din),    0);
    check("ar.err",       32'(err_sticky), 0);
    check("ar.cmd_ready", 32'(cmd_ready),  1);
    check("ar.rsp_valid", 32'(rsp_valid),  0);
    check("ar.rsp_addr",  32'(rsp_addr),   0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    done_pulse(8'h00);
    check("ar.flushed_busy", 32'(busy),      0);
    check("ar.flushed_addr", 32'(i2c_addr),  32'h7F);
    check("ar.flushed_rsp",  32'(rsp_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
